// File: rtl/cci_rx_response_router.sv
// Steers CCI rx read data and write completions to the frame_reader/frame_writer
// clients by mdata tag bit, and keeps per-client outstanding-write counters.
module cci_rx_response_router #(
  parameter int unsigned MDATA_W = 13,
  parameter int unsigned CNT_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               afu_en,
  input  logic               rx0_rdvalid,
  input  logic               rx0_wrvalid,
  input  logic [MDATA_W-1:0] rx0_mdata,
  input  logic [511:0]       rx0_data,
  input  logic               rx1_wrvalid,
  input  logic [MDATA_W-1:0] rx1_mdata,
  input  logic               rd_issue_reader,
  input  logic               rd_issue_writer,
  input  logic               wr_issue_reader,
  input  logic               wr_issue_writer,
  output logic               reader_rdvalid,
  output logic               writer_rdvalid,
  output logic [MDATA_W-1:0] reader_rdmdata,
  output logic [MDATA_W-1:0] writer_rdmdata,
  output logic [511:0]       reader_rddata,
  output logic [511:0]       writer_rddata,
  output logic [1:0]         reader_wrdone,
  output logic [1:0]         writer_wrdone,
  output logic [CNT_W-1:0]   reader_wr_outstanding,
  output logic [CNT_W-1:0]   writer_wr_outstanding,
  output logic               reader_idle,
  output logic               writer_idle,
  output logic [1:0]         err_underflow,
  output logic [1:0]         err_overflow
);

  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rx0_tag_c;
  logic             rx1_tag_c;
  logic [1:0]       done_reader_c;
  logic [1:0]       done_writer_c;
  logic [CNT_W+1:0] step_reader_c;
  logic [CNT_W+1:0] step_writer_c;
  logic             unused_c;

  assign unused_c  = ^{rd_issue_reader, rd_issue_writer, rx1_mdata[MDATA_W-2:0]};
  assign rx0_tag_c = rx0_mdata[MDATA_W-1];
  assign rx1_tag_c = rx1_mdata[MDATA_W-1];

  // Completions per client this cycle, summed across both rx channels.
  assign done_reader_c = 2'(rx0_wrvalid && !rx0_tag_c) + 2'(rx1_wrvalid && !rx1_tag_c);
  assign done_writer_c = 2'(rx0_wrvalid &&  rx0_tag_c) + 2'(rx1_wrvalid &&  rx1_tag_c);

  // Returns {overflow, underflow, next_count}; issue and completions net out first.
  function automatic logic [CNT_W+1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic             issue,
                                                input logic [1:0]       done);
    logic signed [SUM_W-1:0] sum;
    sum = $signed({2'b00, cnt}) + $signed(SUM_W'(issue)) - $signed(SUM_W'(done));
    if (sum < 0)
      cnt_step = {1'b0, 1'b1, {CNT_W{1'b0}}};
    else if (sum > $signed({2'b00, CNT_MAX}))
      cnt_step = {1'b1, 1'b0, CNT_MAX};
    else
      cnt_step = {2'b00, sum[CNT_W-1:0]};
  endfunction

  assign step_reader_c = cnt_step(reader_wr_outstanding, wr_issue_reader, done_reader_c);
  assign step_writer_c = cnt_step(writer_wr_outstanding, wr_issue_writer, done_writer_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      reader_rdvalid        <= 1'b0;
      writer_rdvalid        <= 1'b0;
      reader_rdmdata        <= '0;
      writer_rdmdata        <= '0;
      reader_rddata         <= '0;
      writer_rddata         <= '0;
      reader_wrdone         <= 2'd0;
      writer_wrdone         <= 2'd0;
      reader_wr_outstanding <= '0;
      writer_wr_outstanding <= '0;
      reader_idle           <= 1'b1;
      writer_idle           <= 1'b1;
      err_underflow         <= 2'b00;
      err_overflow          <= 2'b00;
    end else if (!afu_en) begin
      // Drop responses and clear tracking; data and error history are kept.
      reader_rdvalid        <= 1'b0;
      writer_rdvalid        <= 1'b0;
      reader_wrdone         <= 2'd0;
      writer_wrdone         <= 2'd0;
      reader_wr_outstanding <= '0;
      writer_wr_outstanding <= '0;
      reader_idle           <= 1'b1;
      writer_idle           <= 1'b1;
    end else begin
      reader_rdvalid <= rx0_rdvalid && !rx0_tag_c;
      writer_rdvalid <= rx0_rdvalid &&  rx0_tag_c;
      if (rx0_rdvalid && !rx0_tag_c) begin
        reader_rdmdata <= rx0_mdata;
        reader_rddata  <= rx0_data;
      end
      if (rx0_rdvalid && rx0_tag_c) begin
        writer_rdmdata <= rx0_mdata;
        writer_rddata  <= rx0_data;
      end
      reader_wrdone         <= done_reader_c;
      writer_wrdone         <= done_writer_c;
      reader_wr_outstanding <= step_reader_c[CNT_W-1:0];
      writer_wr_outstanding <= step_writer_c[CNT_W-1:0];
      reader_idle           <= (step_reader_c[CNT_W-1:0] == '0);
      writer_idle           <= (step_writer_c[CNT_W-1:0] == '0);
      err_underflow         <= err_underflow | {step_writer_c[CNT_W], step_reader_c[CNT_W]};
      err_overflow          <= err_overflow  | {step_writer_c[CNT_W+1], step_reader_c[CNT_W+1]};
    end
  end

endmodule
